// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin, packet-granular sharing of one udpip_transmitter
// between NUM_REQ byte-stream requesters. Forwarded bytes appear one cycle
// after acceptance. The next packet is held off until tx_done or a timeout.
// Packets longer than MAX_LEN are truncated, and stray non-first bytes are dropped.

module udp_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_LEN      = 256,
    parameter int unsigned DONE_TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_first,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_in,
    output logic                       tx_in_valid,
    output logic                       tx_in_first,
    output logic                       tx_in_last,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_overflow,
    output logic                       err_timeout,
    output logic                       err_framing
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = $clog2(DONE_TIMEOUT);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_STREAM    = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] last_grant, last_grant_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          done_seen, done_seen_nxt;
    logic [7:0]    tx_in_nxt;
    logic          tx_valid_nxt, tx_first_nxt, tx_last_nxt;
    logic          busy_nxt, ovf_nxt, tmo_nxt, frm_nxt;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] ready_c;
    logic [GW-1:0]      pick;
    logic [GW-1:0]      idx;
    logic               found;
    logic               accept;
    logic               cur_last;
    logic [7:0]         cur_data;
    logic               at_max;
    logic               done_any;

    // Round-robin pick among requesters presenting a first byte, starting after last_grant
    always_comb begin
        cand  = req_valid & req_first;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            idx = GW'((int'(last_grant) + off) % int'(NUM_REQ));
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Mux out the granted requester's byte stream
    always_comb begin
        cur_data = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (GW'(i) == grant_id) begin
                cur_data = req_data[8*i +: 8];
            end
        end
        accept   = req_valid[grant_id];
        cur_last = req_last[grant_id];
        at_max   = (count == CW'(MAX_LEN - 1));
        done_any = done_seen | tx_done;
    end

    // Next-state, ready and registered-output next values
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        count_nxt      = count;
        timer_nxt      = '0;
        done_seen_nxt  = 1'b0;
        tx_in_nxt      = tx_in;
        tx_valid_nxt   = 1'b0;
        tx_first_nxt   = 1'b0;
        tx_last_nxt    = 1'b0;
        ovf_nxt        = 1'b0;
        tmo_nxt        = 1'b0;
        frm_nxt        = 1'b0;
        ready_c        = '0;

        case (state)
            ST_IDLE: begin
                // Orphan bytes are swallowed so they cannot block their requester
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    if (req_valid[i] && !req_first[i]) begin
                        ready_c[i] = 1'b1;
                        frm_nxt    = 1'b1;
                    end
                end
                if (found) begin
                    grant_nxt = pick;
                    count_nxt = '0;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    ready_c[i] = (GW'(i) == grant_id);
                end
                if (accept) begin
                    tx_in_nxt    = cur_data;
                    tx_valid_nxt = 1'b1;
                    tx_first_nxt = (count == '0);
                    tx_last_nxt  = cur_last | at_max;
                    count_nxt    = count + CW'(1);
                    if (cur_last) begin
                        state_nxt = ST_WAIT_DONE;
                    end else if (at_max) begin
                        state_nxt = ST_DRAIN;
                        ovf_nxt   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    ready_c[i] = (GW'(i) == grant_id);
                end
                done_seen_nxt = done_any;
                if (accept && cur_last) begin
                    if (done_any) begin
                        state_nxt      = ST_IDLE;
                        last_grant_nxt = grant_id;
                    end else begin
                        state_nxt = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                timer_nxt = timer + TW'(1);
                if (tx_done) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = grant_id;
                end else if (timer == TW'(DONE_TIMEOUT - 1)) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = grant_id;
                    tmo_nxt        = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Ready is forced low while reset is asserted so every output reads 0
    assign req_ready = rst_n ? ready_c : '0;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            grant_id     <= '0;
            last_grant   <= GW'(NUM_REQ - 1);
            count        <= '0;
            timer        <= '0;
            done_seen    <= 1'b0;
            tx_in        <= 8'h00;
            tx_in_valid  <= 1'b0;
            tx_in_first  <= 1'b0;
            tx_in_last   <= 1'b0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            err_framing  <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant_id     <= grant_nxt;
            last_grant   <= last_grant_nxt;
            count        <= count_nxt;
            timer        <= timer_nxt;
            done_seen    <= done_seen_nxt;
            tx_in        <= tx_in_nxt;
            tx_in_valid  <= tx_valid_nxt;
            tx_in_first  <= tx_first_nxt;
            tx_in_last   <= tx_last_nxt;
            busy         <= busy_nxt;
            err_overflow <= ovf_nxt;
            err_timeout  <= tmo_nxt;
            err_framing  <= frm_nxt;
        end
    end

endmodule
